// File: rtl/riscv_pkg.sv
// Shared RV32I encodings and the MEM/WB pipeline-register layout used by the
// memory and writeback stages.
package riscv_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    typedef struct packed {
        logic        regWrite;
        logic [1:0]  resultSrc;
        logic [4:0]  rd;
        logic [31:0] aluResult;
        logic [31:0] readData;
        logic [31:0] pcPlus4;
    } memWb_t;

    // Halfwords need an even lane, words need lane 0; bytes are always aligned.
    function automatic logic isMisaligned(input logic [2:0] funct3, input logic [1:0] lane);
        case (funct3)
            F3_H, F3_HU: return lane[0];
            F3_W:        return lane != 2'b00;
            default:     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/data_memory.sv
// Word-organised data memory: byte-enabled synchronous write, asynchronous read.
module data_memory #(
    parameter int DEPTH_WORDS = 1024,
    localparam int AW = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          writeEnable,
    input  logic [3:0]    byteEnable,
    input  logic [AW-1:0] wordAddr,
    input  logic [31:0]   writeData,
    output logic [31:0]   readData
);

    logic [31:0] mem [DEPTH_WORDS];

    // NOTE: the array has no reset; clearing it would force a flop-based
    // implementation instead of a RAM, and software never relies on its contents.
    always_ff @(posedge clk) begin
        if (writeEnable) begin
            for (int i = 0; i < 4; i++) begin
                if (byteEnable[i]) begin
                    mem[wordAddr][i*8 +: 8] <= writeData[i*8 +: 8];
                end
            end
        end
    end

    assign readData = mem[wordAddr];

endmodule

// File: rtl/memory_cycle.sv
// M stage: RV32I loads/stores against the data memory, load extension,
// misalignment detection and the MEM/WB pipeline register.
module memory_cycle
    import riscv_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWriteM,
    input  logic        MemWriteM,
    input  logic [1:0]  ResultSrcM,
    input  logic [2:0]  funct3M,
    input  logic [4:0]  RD_M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic [31:0] PCPlus4M,
    input  logic        StallM,
    input  logic        FlushW,
    output logic        MisalignedM,
    output logic        RegWriteW,
    output logic [1:0]  ResultSrcW,
    output logic [4:0]  RD_W,
    output logic [31:0] ALUResultW,
    output logic [31:0] ReadDataW,
    output logic [31:0] PCPlus4W
);

    localparam int AW = $clog2(DEPTH_WORDS);

    logic [1:0]  lane;
    logic        isLoad;
    logic        misalignedRaw;
    logic        validStoreF3;
    logic        validLoadF3;
    logic        loadFault;
    logic        storeEnable;
    logic [3:0]  byteEnable;
    logic [31:0] storeData;
    logic [31:0] readWord;
    logic [7:0]  byteSel;
    logic [15:0] halfSel;
    logic [31:0] loadValue;
    memWb_t      wbD;
    memWb_t      wbQ;

    // Addresses wrap modulo the memory size.
    logic unusedAddrBits;
    assign unusedAddrBits = ^ALUResultM[31:AW+2];

    assign lane          = ALUResultM[1:0];
    assign isLoad        = (ResultSrcM == RES_MEM);
    assign misalignedRaw = isMisaligned(funct3M, lane);
    assign MisalignedM   = misalignedRaw & (MemWriteM | isLoad);
    assign validStoreF3  = (funct3M == F3_B) | (funct3M == F3_H) | (funct3M == F3_W);
    assign validLoadF3   = validStoreF3 | (funct3M == F3_BU) | (funct3M == F3_HU);
    assign loadFault     = isLoad & (misalignedRaw | ~validLoadF3);
    assign storeEnable   = MemWriteM & ~misalignedRaw & validStoreF3 & ~StallM;

    // NOTE: every output of this block gets a default first so no path
    // through the case leaves it unassigned and infers a latch.
    always_comb begin
        byteEnable = 4'b0000;
        storeData  = WriteDataM;
        case (funct3M)
            F3_B: begin
                byteEnable = 4'b0001 << lane;
                storeData  = {4{WriteDataM[7:0]}};
            end
            F3_H: begin
                byteEnable = ALUResultM[1] ? 4'b1100 : 4'b0011;
                storeData  = {2{WriteDataM[15:0]}};
            end
            F3_W:    byteEnable = 4'b1111;
            default: byteEnable = 4'b0000;
        endcase
    end

    data_memory #(.DEPTH_WORDS(DEPTH_WORDS)) u_data_memory (
        .clk        (clk),
        .writeEnable(storeEnable),
        .byteEnable (byteEnable),
        .wordAddr   (ALUResultM[AW+1:2]),
        .writeData  (storeData),
        .readData   (readWord)
    );

    assign byteSel = readWord[{lane, 3'b000} +: 8];
    assign halfSel = ALUResultM[1] ? readWord[31:16] : readWord[15:0];

    always_comb begin
        loadValue = 32'h0;
        case (funct3M)
            F3_B:    loadValue = {{24{byteSel[7]}}, byteSel};
            F3_BU:   loadValue = {24'h0, byteSel};
            F3_H:    loadValue = {{16{halfSel[15]}}, halfSel};
            F3_HU:   loadValue = {16'h0, halfSel};
            F3_W:    loadValue = readWord;
            default: loadValue = 32'h0;
        endcase
    end

    always_comb begin
        wbD.regWrite  = RegWriteM & ~loadFault;
        wbD.resultSrc = ResultSrcM;
        wbD.rd        = RD_M;
        wbD.aluResult = ALUResultM;
        wbD.readData  = loadFault ? 32'h0 : loadValue;
        wbD.pcPlus4   = PCPlus4M;
    end

    // NOTE: pipeline state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wbQ <= '0;
        end else if (FlushW) begin
            wbQ <= '0;
        end else if (!StallM) begin
            wbQ <= wbD;
        end
    end

    assign RegWriteW  = wbQ.regWrite;
    assign ResultSrcW = wbQ.resultSrc;
    assign RD_W       = wbQ.rd;
    assign ALUResultW = wbQ.aluResult;
    assign ReadDataW  = wbQ.readData;
    assign PCPlus4W   = wbQ.pcPlus4;

endmodule

// File: tb/tb_memory_cycle.sv
// Directed self-checking bench for memory_cycle with hand-computed expectations.
module tb_memory_cycle;
    import riscv_pkg::*;

    logic        clk;
    logic        rst;
    logic        RegWriteM;
    logic        MemWriteM;
    logic [1:0]  ResultSrcM;
    logic [2:0]  funct3M;
    logic [4:0]  RD_M;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [31:0] PCPlus4M;
    logic        StallM;
    logic        FlushW;
    logic        MisalignedM;
    logic        RegWriteW;
    logic [1:0]  ResultSrcW;
    logic [4:0]  RD_W;
    logic [31:0] ALUResultW;
    logic [31:0] ReadDataW;
    logic [31:0] PCPlus4W;

    int testsRun  = 0;
    int failCount = 0;

    memory_cycle #(.DEPTH_WORDS(1024)) dut (
        .clk        (clk),
        .rst        (rst),
        .RegWriteM  (RegWriteM),
        .MemWriteM  (MemWriteM),
        .ResultSrcM (ResultSrcM),
        .funct3M    (funct3M),
        .RD_M       (RD_M),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .PCPlus4M   (PCPlus4M),
        .StallM     (StallM),
        .FlushW     (FlushW),
        .MisalignedM(MisalignedM),
        .RegWriteW  (RegWriteW),
        .ResultSrcW (ResultSrcW),
        .RD_W       (RD_W),
        .ALUResultW (ALUResultW),
        .ReadDataW  (ReadDataW),
        .PCPlus4W   (PCPlus4W)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            failCount++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rw, input logic mw, input logic [1:0] rs,
                         input logic [2:0] f3, input logic [4:0] rd,
                         input logic [31:0] addr, input logic [31:0] wd);
        RegWriteM  = rw;
        MemWriteM  = mw;
        ResultSrcM = rs;
        funct3M    = f3;
        RD_M       = rd;
        ALUResultM = addr;
        WriteDataM = wd;
        PCPlus4M   = addr + 32'h100;
    endtask

    task automatic doStore(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
        drive(1'b0, 1'b1, RES_ALU, f3, 5'd0, addr, wd);
        tick();
    endtask

    task automatic doLoad(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd);
        drive(1'b1, 1'b0, RES_MEM, f3, rd, addr, 32'h0);
        tick();
    endtask

    task automatic checkBubble(input string tag);
        check({tag, "_rw"},  {31'h0, RegWriteW}, 32'h0);
        check({tag, "_rs"},  {30'h0, ResultSrcW}, 32'h0);
        check({tag, "_rd"},  {27'h0, RD_W}, 32'h0);
        check({tag, "_alu"}, ALUResultW, 32'h0);
        check({tag, "_rdata"}, ReadDataW, 32'h0);
        check({tag, "_pc4"}, PCPlus4W, 32'h0);
    endtask

    initial begin
        rst    = 1'b0;
        StallM = 1'b0;
        FlushW = 1'b0;
        drive(1'b1, 1'b0, RES_MEM, F3_W, 5'd4, 32'h20, 32'h0);
        #22;
        checkBubble("reset");
        rst = 1'b1;

        doStore(F3_W, 32'h10, 32'hDEADBEEF);
        check("sw_rw", {31'h0, RegWriteW}, 32'h0);
        doLoad(F3_W, 32'h10, 5'd5);
        check("lw_data", ReadDataW, 32'hDEADBEEF);
        check("lw_rw", {31'h0, RegWriteW}, 32'h1);
        check("lw_rd", {27'h0, RD_W}, 32'd5);
        check("lw_rs", {30'h0, ResultSrcW}, {30'h0, RES_MEM});
        check("lw_pc4", PCPlus4W, 32'h110);

        doLoad(F3_B, 32'h13, 5'd6);
        check("lb", ReadDataW, 32'hFFFFFFDE);
        doLoad(F3_BU, 32'h13, 5'd6);
        check("lbu", ReadDataW, 32'h000000DE);
        doLoad(F3_H, 32'h12, 5'd6);
        check("lh", ReadDataW, 32'hFFFFDEAD);
        doLoad(F3_HU, 32'h10, 5'd6);
        check("lhu", ReadDataW, 32'h0000BEEF);
        doLoad(F3_B, 32'h10, 5'd6);
        check("lb_pos", ReadDataW, 32'hFFFFFFEF);

        doStore(F3_B, 32'h11, 32'hAAAAAA55);
        doLoad(F3_W, 32'h10, 5'd6);
        check("sb_readback", ReadDataW, 32'hDEAD55EF);
        doStore(F3_H, 32'h12, 32'hCCCC1234);
        doLoad(F3_W, 32'h10, 5'd6);
        check("sh_readback", ReadDataW, 32'h123455EF);

        drive(1'b1, 1'b0, RES_MEM, F3_W, 5'd6, 32'h11, 32'h0);
        #1;
        check("mis_lw_flag", {31'h0, MisalignedM}, 32'h1);
        tick();
        check("mis_lw_rw", {31'h0, RegWriteW}, 32'h0);
        check("mis_lw_data", ReadDataW, 32'h0);
        drive(1'b1, 1'b0, RES_MEM, F3_HU, 5'd6, 32'h13, 32'h0);
        #1;
        check("mis_lhu_flag", {31'h0, MisalignedM}, 32'h1);
        drive(1'b1, 1'b0, RES_ALU, F3_W, 5'd6, 32'h11, 32'h0);
        #1;
        check("mis_noaccess", {31'h0, MisalignedM}, 32'h0);
        drive(1'b0, 1'b1, RES_ALU, F3_W, 5'd0, 32'h12, 32'hFFFFFFFF);
        #1;
        check("mis_sw_flag", {31'h0, MisalignedM}, 32'h1);
        tick();
        doLoad(F3_W, 32'h10, 5'd6);
        check("mis_sw_nowrite", ReadDataW, 32'h123455EF);
        check("aligned_flag", {31'h0, MisalignedM}, 32'h0);

        doLoad(3'b011, 32'h10, 5'd6);
        check("undef_rw", {31'h0, RegWriteW}, 32'h0);
        check("undef_data", ReadDataW, 32'h0);

        drive(1'b1, 1'b0, RES_ALU, F3_W, 5'd12, 32'h10, 32'h0);
        tick();
        check("alu_rw", {31'h0, RegWriteW}, 32'h1);
        check("alu_rdata", ReadDataW, 32'h123455EF);
        drive(1'b1, 1'b0, RES_PC4, 3'b110, 5'd13, 32'h44, 32'h0);
        tick();
        check("pc4_rw", {31'h0, RegWriteW}, 32'h1);
        check("pc4_rs", {30'h0, ResultSrcW}, {30'h0, RES_PC4});
        check("pc4_val", PCPlus4W, 32'h144);

        doLoad(F3_W, 32'h10, 5'd7);
        drive(1'b0, 1'b1, RES_ALU, F3_W, 5'd0, 32'h10, 32'h11111111);
        StallM = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("stall_rd", {27'h0, RD_W}, 32'd7);
            check("stall_rw", {31'h0, RegWriteW}, 32'h1);
            check("stall_data", ReadDataW, 32'h123455EF);
            check("stall_alu", ALUResultW, 32'h10);
        end
        StallM = 1'b0;
        doLoad(F3_W, 32'h10, 5'd8);
        check("stall_nowrite", ReadDataW, 32'h123455EF);
        check("stall_release_rd", {27'h0, RD_W}, 32'd8);

        FlushW = 1'b1;
        doLoad(F3_W, 32'h10, 5'd9);
        checkBubble("flush");
        StallM = 1'b1;
        doStore(F3_W, 32'h10, 32'h22222222);
        checkBubble("flush_stall");
        StallM = 1'b0;
        FlushW = 1'b0;
        doLoad(F3_W, 32'h10, 5'd9);
        check("flush_stall_nowrite", ReadDataW, 32'h123455EF);

        doLoad(F3_W, 32'h10, 5'd3);
        check("prereset_rw", {31'h0, RegWriteW}, 32'h1);
        #2;
        rst = 1'b0;
        #1;
        checkBubble("async_rst");
        #1;
        rst = 1'b1;

        doStore(F3_W, 32'd4096, 32'hCAFEF00D);
        doLoad(F3_W, 32'h0, 5'd10);
        check("wrap", ReadDataW, 32'hCAFEF00D);
        doLoad(F3_W, 32'h10, 5'd10);
        check("wrap_other_word", ReadDataW, 32'h123455EF);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
